// File: rtl/spi_tx.sv
// SPI mode-0 transmitter: takes a parallel word on a start/busy handshake,
// shifts it out MSB-first and reports frame completion with a one-cycle done pulse.
module spi_tx #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              spi_mosi,
  output logic              spi_clk,
  output logic              spi_cs
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_FIRST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    TRAIL = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mosi_q, mosi_d;
  logic              sclk_q, sclk_d;
  logic              cs_q, cs_d;
  logic              phase_end_s;
  logic [DATA_W-1:0] shift_next_s;

  assign phase_end_s  = (div_q == DIV_LAST);
  assign shift_next_s = shift_q << 1'b1;

  // Next-state and next-output logic; every phase lasts CLK_DIV cycles.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mosi_d  = mosi_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          shift_d = data;
          bit_d   = BIT_FIRST;
          div_d   = '0;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = data[DATA_W-1];
          state_d = LOW;
        end else begin
          state_d = IDLE;
        end
      end
      LOW: begin
        if (phase_end_s) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = HIGH;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      HIGH: begin
        if (phase_end_s) begin
          div_d  = '0;
          sclk_d = 1'b0;
          // The next bit is presented on the falling edge so the receiver sees it settled.
          if (bit_q != '0) begin
            bit_d   = bit_q - BIT_W'(1);
            shift_d = shift_next_s;
            mosi_d  = shift_next_s[DATA_W-1];
            state_d = LOW;
          end else begin
            mosi_d  = 1'b0;
            state_d = TRAIL;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      TRAIL: begin
        if (phase_end_s) begin
          div_d   = '0;
          cs_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mosi_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mosi_q  <= mosi_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_mosi = mosi_q;
  assign spi_clk  = sclk_q;
  assign spi_cs   = cs_q;

endmodule
